// File: rtl/vector_scale_seq.sv
// vector_scale_seq: scales a three-component signed fixed-point vector by a
// signed scalar. One W x W multiplier is shared across the components over
// three cycles.
//
// Word format: W = D+Q bit two's complement, Q fractional bits. Each
// component is bits [Q+W-1:Q] of the full 2W-bit product. This is an
// arithmetic shift that rounds toward negative infinity.
//
// Optional feature, selected by the macro VECTOR_SCALE_SAT_EN:
//   defined   - a component that overflows W bits clamps to the max or min
//               representable value
//   undefined - a component is the plain slice, so overflow wraps around
// Rounding and timing are the same in both builds.
//
// Handshake: new_data is accepted at a rising edge where ready=1.
// ready is high in IDLE and DONE and low while the multiplier is busy.
// output_valid is a one-cycle strobe in the DONE cycle. In that same cycle
// r presents the new result, and r holds it until the next strobe.
// Accepting at edge E0 gives the state sequence MUL0, MUL1, MUL2, DONE.
// new_data seen in DONE starts the next operation directly, so requests
// held back-to-back produce one result every 4 cycles.
module vector_scale_seq #(
    parameter int D = 8,
    parameter int Q = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     new_data,
    output logic                     ready,
    output logic                     output_valid,
    input  logic [D+Q-1:0]           s,
    input  logic [3*(D+Q)-1:0]       v,
    output logic [3*(D+Q)-1:0]       r,
    output logic [2:0]               dbg_state_o
);

    localparam int W = D + Q;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] MUL0 = 3'd1;
    localparam logic [2:0] MUL1 = 3'd2;
    localparam logic [2:0] MUL2 = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [W-1:0]        s_q;
    logic [3*W-1:0]      v_q;
    logic [3*W-1:0]      res_q;
    logic [3*W-1:0]      r_q;
    logic                valid_q;

    logic                accept;
    logic signed [W-1:0] op_s;
    logic signed [W-1:0] op_v;
    logic signed [2*W-1:0] prod;
    logic [W-1:0]        comp;
    logic                unused_prod_bits;

    assign ready        = (state_q == IDLE) || (state_q == DONE);
    assign accept       = new_data && ready;
    assign output_valid = valid_q;
    assign r            = r_q;
    assign dbg_state_o  = state_q;

    // Next-state logic: the MULk states always advance; IDLE and DONE wait for a request
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = new_data ? MUL0 : IDLE;
            MUL0:    state_d = MUL1;
            MUL1:    state_d = MUL2;
            MUL2:    state_d = DONE;
            DONE:    state_d = new_data ? MUL0 : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Route the component that belongs to the current MULk state into the shared multiplier
    always_comb begin
        op_v = $signed(v_q[0 +: W]);
        case (state_q)
            MUL1:    op_v = $signed(v_q[W +: W]);
            MUL2:    op_v = $signed(v_q[2*W +: W]);
            default: op_v = $signed(v_q[0 +: W]);
        endcase
    end

    assign op_s = $signed(s_q);
    assign prod = op_s * op_v;

    // The bits below the slice are dropped by the floor shift, and without saturation so are the bits above it
    assign unused_prod_bits = ^{prod[2*W-1:Q+W], prod[Q-1:0]};

`ifdef VECTOR_SCALE_SAT_EN
    // Keep the slice only when every bit above it matches the slice's sign bit; otherwise clamp
    always_comb begin
        comp = prod[Q+W-1:Q];
        if (!((&prod[2*W-1:Q+W-1]) || (~|prod[2*W-1:Q+W-1]))) begin
            comp = prod[2*W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end
`else
    // Without saturation the component is simply the slice, so overflow wraps around
    always_comb begin
        comp = prod[Q+W-1:Q];
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture (only on acceptance), per-component results, and the published result/strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q     <= '0;
            v_q     <= '0;
            res_q   <= '0;
            r_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= (state_q == MUL2);
            if (accept) begin
                s_q <= s;
                v_q <= v;
            end
            case (state_q)
                MUL0: res_q[0 +: W]   <= comp;
                MUL1: res_q[W +: W]   <= comp;
                MUL2: begin
                    res_q[2*W +: W] <= comp;
                    // r is updated in one step so a partial vector never appears on it
                    r_q             <= {comp, res_q[2*W-1:0]};
                end
                default: ;
            endcase
        end
    end

endmodule
